// File: rtl/lock_pkg.sv
// Shared definitions for the lock: controller state encodings and the
// active-low seven-segment glyphs, in {DP,g,f,e,d,c,b,a} bit order.
package lock_pkg;

    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_INPUT  = 3'd1,
        ST_ERROR  = 3'd2,
        ST_ALARM  = 3'd3,
        ST_UNLOCK = 3'd4
    } lock_state_e;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_R     = 8'hAF;
    localparam logic [7:0] SEG_L     = 8'hC7;
    localparam logic [7:0] SEG_O     = 8'hC0;
    localparam logic [7:0] SEG_P     = 8'h8C;
    localparam logic [7:0] SEG_N     = 8'hAB;
    localparam logic [7:0] SEG_U     = 8'hC1;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_UNDER = 8'hF7;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [2:0] MAX_DIGITS = 3'd4;

    // Thermometer code of n (0..4) on four bits: n ones from the LSB up.
    function automatic logic [3:0] thermo(input logic [2:0] n);
        logic [4:0] t;
        t = (5'd1 << n) - 5'd1;
        return t[3:0];
    endfunction

endpackage

// File: rtl/seg7_glyph.sv
// BCD nibble to active-low seven-segment pattern; nibbles 10-15 are blank.
module seg7_glyph
    import lock_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [7:0] o_seg
);

    always_comb begin
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/lock_display_out.sv
// Board-side display driver for the lock: scans the 8-digit seven-segment
// display, owns blink timing, and maps controller state onto the LEDs.
module lock_display_out
    import lock_pkg::*;
#(
    parameter int SCAN_DIV    = 100000,
    parameter int BLINK_TICKS = 250
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [2:0]  STATE,
    input  logic [15:0] CODE,
    input  logic [2:0]  CODE_BIT,
    input  logic        ID_FLAG,
    input  logic [1:0]  ERROR_TIME,
    output logic [7:0]  AN,
    output logic [7:0]  SEG,
    output logic [15:0] LD
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [PW-1:0] r_presc;
    logic [2:0]    r_idx;
    logic [BW-1:0] r_blink;
    logic          r_phase;

    logic          w_tick;
    logic          w_blink_wrap;
    logic [2:0]    w_code_bit;
    logic [2:0]    w_k;
    logic [3:0]    w_nibble;
    logic [7:0]    w_code_glyph;
    logic [7:0]    w_err_glyph;
    logic [7:0]    w_seg_next;
    logic [15:0]   w_ld_next;

    assign w_tick       = (r_presc == PW'(SCAN_DIV - 1));
    assign w_blink_wrap = (r_blink == BW'(BLINK_TICKS - 1));
    assign w_code_bit   = (CODE_BIT > MAX_DIGITS) ? MAX_DIGITS : CODE_BIT;
    assign w_k          = {1'b0, r_idx[1:0]};
    assign w_nibble     = CODE[{r_idx[1:0], 2'b00} +: 4];

    seg7_glyph u_code_glyph (
        .i_bcd (w_nibble),
        .o_seg (w_code_glyph)
    );

    seg7_glyph u_err_glyph (
        .i_bcd ({2'b00, ERROR_TIME}),
        .o_seg (w_err_glyph)
    );

    // NOTE: every path starts from a default, so no latch can be inferred.
    always_comb begin
        w_seg_next = SEG_BLANK;
        case (STATE)
            ST_WAIT: begin
                if (r_idx == 3'd7)  w_seg_next = ID_FLAG ? SEG_A : SEG_BLANK;
                else if (!r_idx[2]) w_seg_next = SEG_DASH;
            end
            ST_INPUT: begin
                if (r_idx == 3'd7)          w_seg_next = ID_FLAG ? SEG_A : SEG_U;
                else if (r_idx[2])          w_seg_next = SEG_BLANK;
                else if (w_k < w_code_bit)  w_seg_next = w_code_glyph;
                else if (w_k == w_code_bit) w_seg_next = r_phase ? SEG_UNDER : SEG_BLANK;
                else                        w_seg_next = SEG_UNDER;
            end
            ST_ERROR: begin
                case (r_idx)
                    3'd7:    w_seg_next = SEG_E;
                    3'd6:    w_seg_next = SEG_R;
                    3'd5:    w_seg_next = SEG_R;
                    3'd0:    w_seg_next = w_err_glyph;
                    default: w_seg_next = SEG_BLANK;
                endcase
            end
            ST_ALARM: begin
                // Both halves of the display repeat "ALAr" while lit.
                if (r_phase) begin
                    case (r_idx[1:0])
                        2'd3:    w_seg_next = SEG_A;
                        2'd2:    w_seg_next = SEG_L;
                        2'd1:    w_seg_next = SEG_A;
                        default: w_seg_next = SEG_R;
                    endcase
                end
            end
            ST_UNLOCK: begin
                if (!r_idx[2]) begin
                    case (r_idx[1:0])
                        2'd3:    w_seg_next = SEG_O;
                        2'd2:    w_seg_next = SEG_P;
                        2'd1:    w_seg_next = SEG_E;
                        default: w_seg_next = SEG_N;
                    endcase
                end
            end
            default: w_seg_next = SEG_BLANK;
        endcase
    end

    always_comb begin
        w_ld_next       = '0;
        w_ld_next[2:0]  = {&ERROR_TIME, ERROR_TIME[1], |ERROR_TIME};
        w_ld_next[7:4]  = thermo(w_code_bit);
        w_ld_next[13]   = ID_FLAG;
        w_ld_next[14]   = (STATE == ST_UNLOCK);
        w_ld_next[15]   = (STATE == ST_ALARM) && r_phase;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_blink <= '0;
            r_phase <= 1'b1;
            AN      <= 8'hFF;
            SEG     <= SEG_BLANK;
            LD      <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_tick) begin
                r_idx   <= r_idx + 3'd1;
                r_blink <= w_blink_wrap ? '0 : r_blink + BW'(1);
                if (w_blink_wrap) r_phase <= ~r_phase;
            end
            // AN and SEG come from the same r_idx, so they never skew.
            AN  <= ~(8'd1 << r_idx);
            SEG <= w_seg_next;
            LD  <= w_ld_next;
        end
    end

endmodule

// File: tb/tb_lock_display_out.sv
// Self-checking bench for lock_display_out: time-based reference model of
// the scan/blink schedule and the per-state display contents.
module tb_lock_display_out;

    localparam int SD = 4;
    localparam int BT = 2;

    localparam logic [7:0] G_A = 8'h88, G_E = 8'h86, G_R = 8'hAF, G_L = 8'hC7;
    localparam logic [7:0] G_O = 8'hC0, G_P = 8'h8C, G_N = 8'hAB, G_U = 8'hC1;
    localparam logic [7:0] G_DASH = 8'hBF, G_UNDER = 8'hF7, G_BL = 8'hFF;

    logic [7:0] digit_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                   8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  st  = 3'd0;
    logic [15:0] code = 16'h0;
    logic [2:0]  cb  = 3'd0;
    logic        idf = 1'b0;
    logic [1:0]  et  = 2'd0;
    logic [7:0]  an, seg;
    logic [15:0] ld;

    int e = 0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lock_display_out #(.SCAN_DIV(SD), .BLINK_TICKS(BT)) dut (
        .CLK        (clk),
        .RESET      (rst),
        .STATE      (st),
        .CODE       (code),
        .CODE_BIT   (cb),
        .ID_FLAG    (idf),
        .ERROR_TIME (et),
        .AN         (an),
        .SEG        (seg),
        .LD         (ld)
    );

    function automatic logic [7:0] bcd_glyph(input logic [3:0] n);
        return (n < 10) ? digit_tab[n] : G_BL;
    endfunction

    // Glyph expected on digit d given the current inputs and blink phase.
    function automatic logic [7:0] model_seg(input int d, input bit ph);
        int cbc;
        logic [7:0] alar [4];
        logic [7:0] open [4];
        alar = '{G_R, G_A, G_L, G_A};
        open = '{G_N, G_E, G_P, G_O};
        cbc = (cb > 4) ? 4 : int'(cb);
        case (st)
            3'd0: return (d == 7) ? (idf ? G_A : G_BL) : (d >= 4) ? G_BL : G_DASH;
            3'd1: begin
                if (d == 7) return idf ? G_A : G_U;
                if (d >= 4) return G_BL;
                if (d < cbc) return bcd_glyph(code[4*d +: 4]);
                if (d == cbc) return ph ? G_UNDER : G_BL;
                return G_UNDER;
            end
            3'd2: begin
                if (d == 7) return G_E;
                if (d == 6 || d == 5) return G_R;
                if (d == 0) return digit_tab[et];
                return G_BL;
            end
            3'd3: return ph ? alar[d % 4] : G_BL;
            3'd4: return (d < 4) ? open[d] : G_BL;
            default: return G_BL;
        endcase
    endfunction

    function automatic logic [15:0] model_ld(input bit ph);
        logic [15:0] v;
        int cbc;
        cbc = (cb > 4) ? 4 : int'(cb);
        v = '0;
        v[2:0]  = 3'((1 << et) - 1);
        v[7:4]  = 4'((1 << cbc) - 1);
        v[13]   = idf;
        v[14]   = (st == 3'd4);
        v[15]   = (st == 3'd3) && ph;
        return v;
    endfunction

    // One clock; outputs after edge e reflect the schedule after e-1 edges.
    task automatic step(input string tag);
        bit was_rst;
        int m, ticks, d;
        bit ph;
        logic [7:0] x_an, x_seg;
        logic [15:0] x_ld;
        was_rst = rst;
        @(posedge clk);
        if (was_rst) e = 0; else e++;
        @(negedge clk);
        if (was_rst) begin
            x_an = 8'hFF; x_seg = 8'hFF; x_ld = 16'h0;
        end else begin
            m     = e - 1;
            ticks = m / SD;
            d     = ticks % 8;
            ph    = ((ticks / BT) % 2) == 0;
            x_an  = ~(8'd1 << d);
            x_seg = model_seg(d, ph);
            x_ld  = model_ld(ph);
        end
        checks++;
        if (an !== x_an) begin
            failures++;
            $display("FAIL %s AN e=%0d got=%h exp=%h", tag, e, an, x_an);
        end
        checks++;
        if (seg !== x_seg) begin
            failures++;
            $display("FAIL %s SEG e=%0d st=%0d got=%h exp=%h", tag, e, st, seg, x_seg);
        end
        checks++;
        if (ld !== x_ld) begin
            failures++;
            $display("FAIL %s LD e=%0d got=%h exp=%h", tag, e, ld, x_ld);
        end
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run("reset", 3);
        rst = 1'b0;
    endtask

    task automatic test_scan();
        st = 3'd0; idf = 1'b0;
        run("scan_wait", 36);
        idf = 1'b1;
        run("wait_admin", 32);
    endtask

    task automatic test_input();
        st = 3'd1; idf = 1'b0; code = 16'h0037; cb = 3'd2;
        run("input_cb2", 48);
        cb = 3'd4; code = 16'h9A51;
        run("input_full", 32);
        cb = 3'd0;
        run("input_empty", 32);
    endtask

    task automatic test_error();
        st = 3'd2; et = 2'd2; cb = 3'd0; idf = 1'b0;
        run("error", 32);
    endtask

    task automatic test_alarm();
        st = 3'd3; et = 2'd3;
        run("alarm", 48);
    endtask

    task automatic test_unlock();
        st = 3'd4; idf = 1'b1; et = 2'd0;
        run("unlock", 32);
    endtask

    task automatic test_invalid();
        st = 3'd6;
        run("invalid", 32);
        st = 3'd7;
        run("invalid7", 16);
    endtask

    task automatic test_reset_mid_scan();
        int guard = 0;
        st = 3'd1; code = 16'h1234; cb = 3'd3;
        while (((e / SD) % 8) != 5 && guard < 64) begin
            step("pre_reset");
            guard++;
        end
        checks++;
        if (((e / SD) % 8) != 5) begin
            failures++;
            $display("FAIL reset_mid_scan idx got=%0d exp=5", (e / SD) % 8);
        end
        rst = 1'b1;
        step("mid_reset");
        rst = 1'b0;
        run("post_reset", 40);
    endtask

    task automatic test_random();
        for (int s = 0; s < 25; s++) begin
            st   = 3'($urandom_range(0, 7));
            code = 16'($urandom);
            cb   = 3'($urandom_range(0, 7));
            idf  = 1'($urandom);
            et   = 2'($urandom);
            run("random", int'($urandom_range(1, 40)));
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_input();
        test_error();
        test_alarm();
        test_unlock();
        test_invalid();
        test_reset_mid_scan();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
